// File: rtl/minv_reg_unload.sv
// 256-bit operand/result unload register: captures a parallel value and streams it as DW-bit words.
// Optional build macro MINV_UNLOAD_MSW_FIRST_EN selects most-significant-word-first order.
module minv_reg_unload #(
    parameter int DW    = 32,
    parameter int WORDS = 8,
    parameter int CW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DW*WORDS-1:0] din,
    input  logic                replay,
    input  logic                flush,
    output logic [DW-1:0]       dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic                busy,
    output logic                done,
    output logic [CW-1:0]       word_idx
);

    localparam int TW = DW * WORDS;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] sreg_q, sreg_d;
    logic [TW-1:0] sreg_rot;
    logic          has_data_q, has_data_d;
    logic          done_q, done_d;

`ifdef MINV_UNLOAD_MSW_FIRST_EN
    assign dout     = sreg_q[TW-1:TW-DW];
    assign sreg_rot = {sreg_q[TW-DW-1:0], sreg_q[TW-1:TW-DW]};
`else
    assign dout     = sreg_q[DW-1:0];
    assign sreg_rot = {sreg_q[DW-1:0], sreg_q[TW-1:DW]};
`endif

    assign dout_valid = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign dout_last  = (state_q == SEND) && (cnt_q == LAST);
    assign word_idx   = cnt_q;
    assign done       = done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        has_data_d = has_data_q;
        done_d     = 1'b0;
        if (flush) begin
            // sreg keeps its partial rotation; clearing has_data blocks replay of it
            state_d    = IDLE;
            cnt_d      = '0;
            has_data_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        sreg_d     = din;
                        has_data_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = SEND;
                    end else if (replay && has_data_q) begin
                        cnt_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (dout_ready) begin
                        sreg_d = sreg_rot;
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sreg_q     <= '0;
            has_data_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sreg_q     <= sreg_d;
            has_data_q <= has_data_d;
            done_q     <= done_d;
        end
    end

endmodule
